// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM DAC driver: carrier modes,
// counter direction and the signed-to-offset-binary duty conversion.
package pwm_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Flip the sign bit to get offset binary, then align the MSBs onto the CW-bit duty.
    // Caller zero-extends din to 32 bits and truncates the result to CW bits.
    function automatic logic [31:0] to_offset(input logic [31:0] din,
                                              input int unsigned dw,
                                              input int unsigned cw);
        logic [31:0] u;
        u = din ^ (32'd1 << (dw - 1));
        if (dw >= cw)
            return u >> (dw - cw);
        else
            return u << (cw - dw);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: converted sample shadow, active duty updated only at period
// boundaries, and the registered carrier compare.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned CW = 10,
    parameter int unsigned DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic          xfer,
    input  logic [CW-1:0] cnt,
    input  logic [DW-1:0] sample,
    output logic          pwmOut
);

    localparam logic [CW-1:0] DUTY_MID = {1'b1, {(CW-1){1'b0}}};

    logic [CW-1:0] sampleDuty;
    logic [CW-1:0] shadow;
    logic [CW-1:0] duty;

    assign sampleDuty = CW'(to_offset(32'(sample), DW, CW));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            duty   <= DUTY_MID;
            pwmOut <= 1'b0;
        end else begin
            if (load)
                shadow <= sampleDuty;
            if (xfer)
                duty <= shadow;
            pwmOut <= en && (cnt < duty);
        end
    end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM DAC driver: shared edge/centre-aligned carrier, double-buffered
// samples with valid/ready intake, sticky overrun and a period-start pulse.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int unsigned CW = 10,
    parameter int unsigned DW = 12,
    parameter int unsigned CH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode_center,
    input  logic [CH*DW-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             overrun_clr,
    output logic [CH-1:0]    pwm_out,
    output logic             period_start,
    output logic             overrun
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    pwm_mode_e     mode;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cntNext;
    pwm_dir_e      dir;
    pwm_dir_e      dirNext;
    logic          running;
    logic          wrap;
    logic          boundary;
    logic          periodStartNext;
    logic          shadowFull;
    logic          accept;
    logic          xfer;

    assign mode = pwm_mode_e'(mode_center);

    // running delays the first count by one cycle so the first enabled cycle sits at cnt=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            dir     <= DIR_UP;
            running <= 1'b0;
        end else begin
            cnt     <= cntNext;
            dir     <= dirNext;
            running <= en;
        end
    end

    always_comb begin
        cntNext = cnt;
        dirNext = dir;
        wrap    = 1'b0;
        if (!en || !running) begin
            cntNext = '0;
            dirNext = DIR_UP;
        end else if (mode == MODE_EDGE) begin
            cntNext = cnt + CW'(1);
            dirNext = DIR_UP;
            wrap    = (cnt == CNT_MAX);
        end else if (dir == DIR_UP) begin
            if (cnt == CNT_MAX) begin
                cntNext = cnt - CW'(1);
                dirNext = DIR_DOWN;
            end else begin
                cntNext = cnt + CW'(1);
            end
        end else begin
            cntNext = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                dirNext = DIR_UP;
                wrap    = 1'b1;
            end
        end
    end

    always_comb begin
        boundary        = !en || !running || wrap;
        periodStartNext = en && (!running || wrap);
        din_ready       = !shadowFull;
        accept          = din_valid && !shadowFull;
        xfer            = boundary && shadowFull;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
            shadowFull   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            period_start <= periodStartNext;
            if (accept)
                shadowFull <= 1'b1;
            else if (boundary)
                shadowFull <= 1'b0;
            if (din_valid && !din_ready)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : gCh
        pwm_channel #(
            .CW(CW),
            .DW(DW)
        ) uCh (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .load   (accept),
            .xfer   (xfer),
            .cnt    (cnt),
            .sample (din[k*DW +: DW]),
            .pwmOut (pwm_out[k])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: small instance (CW=4, DW=6, CH=2) plus a
// wide instance (CW=10, DW=12) for the conversion full-scale case.
module tb_pwm_multi_ch;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode_center;
    logic [11:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        overrun_clr;
    logic [1:0]  pwm_out;
    logic        period_start;
    logic        overrun;

    logic        en2;
    logic        modeCenter2;
    logic [23:0] din2;
    logic        dinValid2;
    logic        dinReady2;
    logic        overrunClr2;
    logic [1:0]  pwmOut2;
    logic        periodStart2;
    logic        overrun2;

    int vectors;
    int miscompares;

    pwm_multi_ch #(.CW(4), .DW(6), .CH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode_center  (mode_center),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .overrun_clr  (overrun_clr),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .overrun      (overrun)
    );

    pwm_multi_ch #(.CW(10), .DW(12), .CH(2)) dutWide (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en2),
        .mode_center  (modeCenter2),
        .din          (din2),
        .din_valid    (dinValid2),
        .din_ready    (dinReady2),
        .overrun_clr  (overrunClr2),
        .pwm_out      (pwmOut2),
        .period_start (periodStart2),
        .overrun      (overrun2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic waitPs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 64);
    endtask

    task automatic waitReady(output int n);
        n = 0;
        while (!din_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic measure(input int n, output int h0, output int h1, output int ps,
                           output logic [63:0] v0);
        h0 = 0; h1 = 0; ps = 0; v0 = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            ps += int'(period_start);
            v0[i] = pwm_out[0];
        end
    endtask

    task automatic test_reset();
        int n, h0, h1, ps;
        logic [63:0] v0;
        rst_n = 1'b1; en = 1'b0; mode_center = 1'b0; din = '0; din_valid = 1'b0;
        overrun_clr = 1'b0;
        en2 = 1'b0; modeCenter2 = 1'b0; din2 = '0; dinValid2 = 1'b0; overrunClr2 = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({pwm_out, din_ready, overrun, period_start} !== 5'b00100) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected 00100", {pwm_out, din_ready, overrun, period_start});
        end
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        waitPs(n);
        measure(16, h0, h1, ps, v0);
        vectors++;
        if (h0 !== 8 || h1 !== 8) begin
            miscompares++;
            $display("FAIL reset_midscale: got %0d/%0d high expected 8/8", h0, h1);
        end
        vectors++;
        if (ps !== 1) begin
            miscompares++;
            $display("FAIL reset_ps_count: got %0d expected 1", ps);
        end
        din = '0; din_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        waitPs(n);
        @(negedge clk);
        vectors++;
        if (pwm_out !== 2'b11) begin
            miscompares++;
            $display("FAIL pre_reset_high: got %b expected 11", pwm_out);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({pwm_out, din_ready, overrun, period_start} !== 5'b00100) begin
            miscompares++;
            $display("FAIL midperiod_reset: got %b expected 00100", {pwm_out, din_ready, overrun, period_start});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_edge_duty();
        int n, h0, h1, ps;
        logic [63:0] v0;
        din = {6'h1F, 6'h20}; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        waitReady(n);
        waitPs(n);
        vectors++;
        if (n !== 16) begin
            miscompares++;
            $display("FAIL edge_period: got %0d cycles expected 16", n);
        end
        measure(16, h0, h1, ps, v0);
        vectors++;
        if (h0 !== 0 || h1 !== 15) begin
            miscompares++;
            $display("FAIL edge_duty: got %0d/%0d high expected 0/15", h0, h1);
        end
        vectors++;
        if (ps !== 1) begin
            miscompares++;
            $display("FAIL edge_ps_count: got %0d expected 1", ps);
        end
    endtask

    task automatic test_center();
        int n, h0, h1, ps, c;
        logic [63:0] v0;
        logic [29:0] expPat;
        @(negedge clk);
        en = 1'b0; mode_center = 1'b1;
        din = {6'h10, 6'h00}; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL center_drain: got ready %b expected 1", din_ready);
        end
        en = 1'b1;
        waitPs(n);
        waitPs(n);
        vectors++;
        if (n !== 30) begin
            miscompares++;
            $display("FAIL center_period: got %0d cycles expected 30", n);
        end
        measure(30, h0, h1, ps, v0);
        vectors++;
        if (h0 !== 15 || h1 !== 23 || ps !== 1) begin
            miscompares++;
            $display("FAIL center_duty: got %0d/%0d high ps %0d expected 15/23 ps 1", h0, h1, ps);
        end
        for (int i = 0; i < 30; i++) begin
            c = (i <= 15) ? i : 30 - i;
            expPat[i] = (c < 8);
        end
        vectors++;
        if (v0[29:0] !== expPat) begin
            miscompares++;
            $display("FAIL center_shape: got %b expected %b", v0[29:0], expPat);
        end
    endtask

    task automatic test_back_to_back();
        int n, h0, h1, ps;
        logic [63:0] v0;
        @(negedge clk);
        en = 1'b0; mode_center = 1'b0;
        @(negedge clk);
        en = 1'b1;
        waitPs(n);
        repeat (3) @(negedge clk);
        din = {6'h08, 6'h3F}; din_valid = 1'b1;
        #1;
        vectors++;
        if (din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_ready: got %b expected 1", din_ready);
        end
        @(negedge clk);
        din = {6'h1F, 6'h1F};
        vectors++;
        if (din_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second_ready: got %b expected 0", din_ready);
        end
        @(negedge clk);
        din_valid = 1'b0;
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_overrun: got %b expected 1", overrun);
        end
        waitReady(n);
        vectors++;
        if (period_start !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready_at_boundary: got ps %b expected 1 (waited %0d)", period_start, n);
        end
        measure(16, h0, h1, ps, v0);
        vectors++;
        if (h0 !== 7 || h1 !== 10) begin
            miscompares++;
            $display("FAIL b2b_first_applied: got %0d/%0d high expected 7/10", h0, h1);
        end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear: got %b expected 0", overrun);
        end
        din = {6'h08, 6'h3F}; din_valid = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; overrun_clr = 1'b0;
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set_priority: got %b expected 1", overrun);
        end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_reclear: got %b expected 0", overrun);
        end
    endtask

    task automatic test_boundary_race();
        int n, h0, h1, ps;
        logic [63:0] v0;
        waitReady(n);
        waitPs(n);
        repeat (15) @(negedge clk);
        din = {6'h00, 6'h30}; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        vectors++;
        if ({period_start, din_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL race_in_shadow: got ps,ready %b expected 10", {period_start, din_ready});
        end
        measure(16, h0, h1, ps, v0);
        vectors++;
        if (h0 !== 7 || h1 !== 10) begin
            miscompares++;
            $display("FAIL race_old_duty: got %0d/%0d high expected 7/10", h0, h1);
        end
        vectors++;
        if (din_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL race_drained: got ready %b expected 1", din_ready);
        end
        measure(16, h0, h1, ps, v0);
        vectors++;
        if (h0 !== 4 || h1 !== 8) begin
            miscompares++;
            $display("FAIL race_new_duty: got %0d/%0d high expected 4/8", h0, h1);
        end
    endtask

    task automatic test_enable();
        int n, h0, h1, ps;
        logic [63:0] v0;
        waitPs(n);
        repeat (2) @(negedge clk);
        din = {6'h20, 6'h1F}; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; en = 1'b0;
        vectors++;
        if (din_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_pending: got ready %b expected 0", din_ready);
        end
        @(negedge clk);
        vectors++;
        if ({pwm_out, din_ready, period_start} !== 4'b0010) begin
            miscompares++;
            $display("FAIL enable_off_state: got %b expected 0010", {pwm_out, din_ready, period_start});
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (pwm_out !== 2'b00) begin
            miscompares++;
            $display("FAIL enable_off_low: got %b expected 00", pwm_out);
        end
        en = 1'b1;
        @(negedge clk);
        vectors++;
        if (period_start !== 1'b1) begin
            miscompares++;
            $display("FAIL enable_first_ps: got %b expected 1", period_start);
        end
        measure(16, h0, h1, ps, v0);
        vectors++;
        if (h0 !== 15 || h1 !== 0 || ps !== 1) begin
            miscompares++;
            $display("FAIL enable_new_duty: got %0d/%0d high ps %0d expected 15/0 ps 1", h0, h1, ps);
        end
    endtask

    task automatic test_wide();
        int n, h0, h1, ps;
        @(negedge clk);
        din2 = {12'h800, 12'h7FF}; dinValid2 = 1'b1;
        @(negedge clk);
        dinValid2 = 1'b0;
        @(negedge clk);
        vectors++;
        if (dinReady2 !== 1'b1) begin
            miscompares++;
            $display("FAIL wide_drain: got ready %b expected 1", dinReady2);
        end
        en2 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!periodStart2 && n < 4096);
        h0 = 0; h1 = 0; ps = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            h0 += int'(pwmOut2[0]);
            h1 += int'(pwmOut2[1]);
            ps += int'(periodStart2);
        end
        vectors++;
        if (h0 !== 1023 || h1 !== 0 || ps !== 1) begin
            miscompares++;
            $display("FAIL wide_fullscale: got %0d/%0d high ps %0d expected 1023/0 ps 1", h0, h1, ps);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_edge_duty();
        test_center();
        test_back_to_back();
        test_boundary_race();
        test_enable();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
